// File: rtl/bp_me_pkg.sv
// Shared helpers for the DRAM link scheduler: link-select width and link id type.
package bp_me_pkg;

    typedef logic [3:0] bp_dram_link_id_t;

    function automatic int link_sel_width(input int num_links);
        return (num_links > 1) ? $clog2(num_links) : 1;
    endfunction

endpackage

// File: rtl/bp_dram_link_order_fifo.sv
// Order FIFO of link ids: records which link each in-flight request went to, in issue order.
module bp_dram_link_order_fifo
    import bp_me_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 32,
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_w_lp = $clog2(els_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                push_i,
    input  logic [width_p-1:0]  data_i,
    input  logic                pop_i,
    output logic [width_p-1:0]  data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [cnt_w_lp-1:0] count_o
);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] rptr_q, wptr_q;
    logic [cnt_w_lp-1:0] count_q;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= ptr_next(wptr_q);
            if (pop_i)  rptr_q <= ptr_next(rptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign full_o  = (count_q == cnt_w_lp'(els_p));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assert property (@(posedge clk_i) disable iff (reset_i) !(push_i && full_o && !pop_i));
    assert property (@(posedge clk_i) disable iff (reset_i) !(pop_i && empty_o));

endmodule

// File: rtl/bp_dram_link_scheduler.sv
// Steers one mem command stream across DRAM links by address interleave and
// returns link responses to the core in original issue order.
module bp_dram_link_scheduler
    import bp_me_pkg::*;
#(
    parameter int num_links_p       = 2,
    parameter int msg_width_p       = 64,
    parameter int addr_lsb_p        = 0,
    parameter int sel_bit_p         = 6,
    parameter int max_outstanding_p = 32,
    parameter int link_credits_p    = 16,
    localparam int out_w_lp = $clog2(max_outstanding_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [msg_width_p-1:0]             mem_cmd_i,
    input  logic                               mem_cmd_v_i,
    output logic                               mem_cmd_ready_o,
    output logic [msg_width_p-1:0]             mem_resp_o,
    output logic                               mem_resp_v_o,
    input  logic                               mem_resp_yumi_i,
    output logic [num_links_p*msg_width_p-1:0] link_cmd_o,
    output logic [num_links_p-1:0]             link_cmd_v_o,
    input  logic [num_links_p-1:0]             link_cmd_ready_i,
    input  logic [num_links_p*msg_width_p-1:0] link_resp_i,
    input  logic [num_links_p-1:0]             link_resp_v_i,
    output logic [num_links_p-1:0]             link_resp_yumi_o,
    output logic [out_w_lp-1:0]                outstanding_o,
    output logic                               idle_o
);

    localparam int lg_links_lp = link_sel_width(num_links_p);
    localparam int cred_w_lp   = $clog2(link_credits_p + 1);
    localparam logic [cred_w_lp-1:0] cred_max_lp = cred_w_lp'(link_credits_p);

    logic [lg_links_lp-1:0] sel, head;
    logic [cred_w_lp-1:0]   credit_q [num_links_p];
    logic [num_links_p-1:0] credit_ok, inc, dec;
    logic order_full, order_empty, cmd_go, accept, pop;

    assign sel = mem_cmd_i[addr_lsb_p+sel_bit_p +: lg_links_lp];

    always_comb begin
        credit_ok = '0;
        for (int k = 0; k < num_links_p; k++) credit_ok[k] = (credit_q[k] < cred_max_lp);
    end

    // Ready and valid are derived independently so neither side waits on the other.
    assign cmd_go          = credit_ok[sel] & ~order_full & ~reset_i;
    assign mem_cmd_ready_o = link_cmd_ready_i[sel] & cmd_go;
    assign link_cmd_v_o    = (mem_cmd_v_i & cmd_go) ? (num_links_p'(1) << sel) : '0;
    assign link_cmd_o      = {num_links_p{mem_cmd_i}};
    assign accept          = mem_cmd_v_i & mem_cmd_ready_o;

    assign mem_resp_v_o     = ~order_empty & link_resp_v_i[head];
    assign mem_resp_o       = link_resp_i[head*msg_width_p +: msg_width_p];
    assign pop              = mem_resp_yumi_i & mem_resp_v_o;
    assign link_resp_yumi_o = pop ? (num_links_p'(1) << head) : '0;

    assign inc = accept ? (num_links_p'(1) << sel) : '0;
    assign dec = link_resp_yumi_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < num_links_p; k++) credit_q[k] <= '0;
        end else begin
            for (int k = 0; k < num_links_p; k++) begin
                case ({inc[k], dec[k]})
                    2'b10:   credit_q[k] <= credit_q[k] + 1'b1;
                    2'b01:   credit_q[k] <= credit_q[k] - 1'b1;
                    default: credit_q[k] <= credit_q[k];
                endcase
            end
        end
    end

    bp_dram_link_order_fifo #(
        .width_p (lg_links_lp),
        .els_p   (max_outstanding_p)
    ) order_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (accept),
        .data_i  (sel),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (order_full),
        .empty_o (order_empty),
        .count_o (outstanding_o)
    );

    assign idle_o = (outstanding_o == '0);

    assert property (@(posedge clk_i) disable iff (reset_i) mem_resp_yumi_i |-> mem_resp_v_o);

    for (genvar g = 0; g < num_links_p; g++) begin : g_link_chk
        assert property (@(posedge clk_i) disable iff (reset_i) link_resp_v_i[g] |-> credit_q[g] != '0);
        assert property (@(posedge clk_i) disable iff (reset_i) credit_q[g] <= cred_max_lp);
    end

endmodule

// File: tb/tb_bp_dram_link_scheduler.sv
// Bench for bp_dram_link_scheduler: directed scenarios plus a randomized run against a queue model.
module tb_bp_dram_link_scheduler;

    localparam int NL = 2;
    localparam int MW = 48;
    localparam int AL = 8;
    localparam int SB = 6;
    localparam int MO = 8;
    localparam int LC = 4;
    localparam int OW = $clog2(MO + 1);

    typedef logic [MW-1:0] msg_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [MW-1:0]    mem_cmd;
    logic             mem_cmd_v;
    logic             mem_cmd_ready;
    logic [MW-1:0]    mem_resp;
    logic             mem_resp_v;
    logic             mem_resp_yumi;
    logic [NL*MW-1:0] link_cmd;
    logic [NL-1:0]    link_cmd_v;
    logic [NL-1:0]    link_cmd_ready;
    logic [NL*MW-1:0] link_resp;
    logic [NL-1:0]    link_resp_v;
    logic [NL-1:0]    link_resp_yumi;
    logic [OW-1:0]    outstanding;
    logic             idle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bp_dram_link_scheduler #(
        .num_links_p       (NL),
        .msg_width_p       (MW),
        .addr_lsb_p        (AL),
        .sel_bit_p         (SB),
        .max_outstanding_p (MO),
        .link_credits_p    (LC)
    ) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .mem_cmd_i        (mem_cmd),
        .mem_cmd_v_i      (mem_cmd_v),
        .mem_cmd_ready_o  (mem_cmd_ready),
        .mem_resp_o       (mem_resp),
        .mem_resp_v_o     (mem_resp_v),
        .mem_resp_yumi_i  (mem_resp_yumi),
        .link_cmd_o       (link_cmd),
        .link_cmd_v_o     (link_cmd_v),
        .link_cmd_ready_i (link_cmd_ready),
        .link_resp_i      (link_resp),
        .link_resp_v_i    (link_resp_v),
        .link_resp_yumi_o (link_resp_yumi),
        .outstanding_o    (outstanding),
        .idle_o           (idle)
    );

    function automatic msg_t mk_cmd(input logic [39:0] addr, input logic [7:0] tag);
        return {addr, tag};
    endfunction

    function automatic msg_t mk_resp(input msg_t cmd, input int k);
        msg_t r;
        r = cmd;
        r[7:0] = 8'hC0 ^ 8'(k);
        return r;
    endfunction

    task automatic idle_inputs();
        mem_cmd        = '0;
        mem_cmd_v      = 1'b0;
        mem_resp_yumi  = 1'b0;
        link_cmd_ready = '0;
        link_resp      = '0;
        link_resp_v    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [39:0] addr, input logic [7:0] tag);
        mem_cmd   = mk_cmd(addr, tag);
        mem_cmd_v = 1'b1;
        tick();
        mem_cmd_v = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        mem_cmd_v      = 1'b1;
        link_cmd_ready = 2'b11;
        #1;
        total++; if (mem_cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", mem_cmd_ready); end
        total++; if (link_cmd_v !== 2'b00) begin bad++; $display("FAIL reset_link_cmd_v got=%b want=00", link_cmd_v); end
        total++; if (mem_resp_v !== 1'b0) begin bad++; $display("FAIL reset_resp_v got=%b want=0", mem_resp_v); end
        total++; if (outstanding !== '0 || idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%0d/%b want=0/1", outstanding, idle); end
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        total++; if (link_resp_yumi !== 2'b00) begin bad++; $display("FAIL reset_yumi got=%b want=00", link_resp_yumi); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        do_reset();
        link_cmd_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            mem_cmd   = mk_cmd(40'(i * 64), 8'(i));
            mem_cmd_v = 1'b1;
            #1;
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (link_cmd_v !== exp) begin bad++; $display("FAIL b2b_link_cmd_v[%0d] got=%b want=%b", i, link_cmd_v, exp); end
            total++; if (mem_cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, mem_cmd_ready); end
            total++; if (link_cmd[MW +: MW] !== mk_cmd(40'(i * 64), 8'(i))) begin bad++; $display("FAIL b2b_lane1[%0d] got=%h", i, link_cmd[MW +: MW]); end
            tick();
        end
        mem_cmd_v = 1'b0;
        #1;
        total++; if (outstanding !== OW'(3) || idle !== 1'b0) begin bad++; $display("FAIL b2b_outstanding got=%0d/%b want=3/0", outstanding, idle); end
    endtask

    task automatic test_hold_order();
        msg_t r0, r1;
        do_reset();
        link_cmd_ready = 2'b11;
        issue(40'h000, 8'h11);
        issue(40'h040, 8'h22);
        r0 = mk_resp(mk_cmd(40'h000, 8'h11), 0);
        r1 = mk_resp(mk_cmd(40'h040, 8'h22), 1);
        link_resp[MW +: MW] = r1;
        link_resp_v = 2'b10;
        #1;
        total++; if (mem_resp_v !== 1'b0 || link_resp_yumi !== 2'b00) begin bad++; $display("FAIL hold_nonhead got=%b/%b want=0/00", mem_resp_v, link_resp_yumi); end
        tick();
        total++; if (mem_resp_v !== 1'b0) begin bad++; $display("FAIL hold_nonhead2 got=%b want=0", mem_resp_v); end
        link_resp[0 +: MW] = r0;
        link_resp_v = 2'b11;
        #1;
        total++; if (mem_resp_v !== 1'b1 || mem_resp !== r0) begin bad++; $display("FAIL hold_first got=%b/%h want=1/%h", mem_resp_v, mem_resp, r0); end
        mem_resp_yumi = 1'b1;
        #1;
        total++; if (link_resp_yumi !== 2'b01) begin bad++; $display("FAIL hold_yumi0 got=%b want=01", link_resp_yumi); end
        tick();
        link_resp_v   = 2'b10;
        mem_resp_yumi = 1'b0;
        #1;
        total++; if (mem_resp_v !== 1'b1 || mem_resp !== r1) begin bad++; $display("FAIL hold_second got=%b/%h want=1/%h", mem_resp_v, mem_resp, r1); end
        mem_resp_yumi = 1'b1;
        #1;
        total++; if (link_resp_yumi !== 2'b10) begin bad++; $display("FAIL hold_yumi1 got=%b want=10", link_resp_yumi); end
        tick();
        mem_resp_yumi = 1'b0;
        link_resp_v   = 2'b00;
        #1;
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL hold_idle got=%b want=1", idle); end
    endtask

    task automatic test_credit_limit();
        do_reset();
        link_cmd_ready = 2'b11;
        for (int i = 0; i < 4; i++) issue(40'(i * 128), 8'(i));
        mem_cmd   = mk_cmd(40'h200, 8'h44);
        mem_cmd_v = 1'b1;
        #1;
        total++; if (mem_cmd_ready !== 1'b0 || link_cmd_v !== 2'b00) begin bad++; $display("FAIL credit_stall got=%b/%b want=0/00", mem_cmd_ready, link_cmd_v); end
        tick();
        link_resp[0 +: MW] = mk_resp(mk_cmd(40'h000, 8'h00), 0);
        link_resp_v   = 2'b01;
        mem_resp_yumi = 1'b1;
        #1;
        total++; if (mem_cmd_ready !== 1'b0) begin bad++; $display("FAIL credit_same_cycle got=%b want=0", mem_cmd_ready); end
        tick();
        link_resp_v   = 2'b00;
        mem_resp_yumi = 1'b0;
        #1;
        total++; if (mem_cmd_ready !== 1'b1 || link_cmd_v !== 2'b01) begin bad++; $display("FAIL credit_release got=%b/%b want=1/01", mem_cmd_ready, link_cmd_v); end
        tick();
        mem_cmd_v = 1'b0;
        #1;
        total++; if (outstanding !== OW'(4)) begin bad++; $display("FAIL credit_outstanding got=%0d want=4", outstanding); end
    endtask

    task automatic test_order_full();
        do_reset();
        link_cmd_ready = 2'b11;
        for (int i = 0; i < 8; i++) issue(40'(i * 64), 8'(i));
        mem_cmd   = mk_cmd(40'h000, 8'h99);
        mem_cmd_v = 1'b1;
        #1;
        total++; if (mem_cmd_ready !== 1'b0 || link_cmd_v !== 2'b00) begin bad++; $display("FAIL full_stall got=%b/%b want=0/00", mem_cmd_ready, link_cmd_v); end
        total++; if (outstanding !== OW'(8) || idle !== 1'b0) begin bad++; $display("FAIL full_count got=%0d/%b want=8/0", outstanding, idle); end
        tick();
        mem_cmd_v = 1'b0;
        #1;
    endtask

    task automatic test_simultaneous();
        do_reset();
        link_cmd_ready = 2'b11;
        issue(40'h000, 8'h01);
        issue(40'h080, 8'h02);
        mem_cmd   = mk_cmd(40'h100, 8'h03);
        mem_cmd_v = 1'b1;
        link_resp[0 +: MW] = mk_resp(mk_cmd(40'h000, 8'h01), 0);
        link_resp_v   = 2'b01;
        mem_resp_yumi = 1'b1;
        #1;
        total++; if (mem_cmd_ready !== 1'b1 || mem_resp_v !== 1'b1) begin bad++; $display("FAIL simul_both got=%b/%b want=1/1", mem_cmd_ready, mem_resp_v); end
        tick();
        mem_cmd_v     = 1'b0;
        link_resp_v   = 2'b00;
        mem_resp_yumi = 1'b0;
        #1;
        total++; if (outstanding !== OW'(2)) begin bad++; $display("FAIL simul_outstanding got=%0d want=2", outstanding); end
        issue(40'h180, 8'h04);
        issue(40'h200, 8'h05);
        mem_cmd   = mk_cmd(40'h280, 8'h06);
        mem_cmd_v = 1'b1;
        #1;
        total++; if (mem_cmd_ready !== 1'b0) begin bad++; $display("FAIL simul_credit got=%b want=0", mem_cmd_ready); end
        mem_cmd_v = 1'b0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        link_cmd_ready = 2'b11;
        for (int i = 0; i < 3; i++) issue(40'(i * 64), 8'(i));
        mem_cmd_v   = 1'b1;
        link_resp_v = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        total++; if (outstanding !== '0 || idle !== 1'b1) begin bad++; $display("FAIL midreset_idle got=%0d/%b want=0/1", outstanding, idle); end
        total++; if (mem_resp_v !== 1'b0 || link_cmd_v !== 2'b00 || link_resp_yumi !== 2'b00 || mem_cmd_ready !== 1'b0) begin
            bad++; $display("FAIL midreset_outs got=%b/%b/%b/%b want=0/00/00/0", mem_resp_v, link_cmd_v, link_resp_yumi, mem_cmd_ready);
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_random();
        msg_t           lq [NL][$];
        int             iq [$];
        msg_t           lane [NL];
        logic [63:0]    r;
        msg_t           cmd, exp_resp;
        int             sel, hd;
        logic [NL-1:0]  rv, lrdy, exp_lv, exp_yumi;
        logic           cv, yumi, exp_ready, exp_rv, ok, full;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r    = {$urandom(), $urandom()};
            cmd  = r[MW-1:0];
            sel  = int'(cmd[AL+SB]);
            cv   = ($urandom_range(0, 9) < 7);
            lrdy = 2'($urandom());
            for (int k = 0; k < NL; k++) begin
                rv[k]   = (lq[k].size() > 0) && ($urandom_range(0, 1) == 1);
                lane[k] = rv[k] ? mk_resp(lq[k][0], k) : msg_t'({$urandom(), $urandom()});
            end
            full      = (iq.size() == MO);
            ok        = (lq[sel].size() < LC);
            exp_ready = lrdy[sel] && ok && !full;
            exp_lv    = (cv && ok && !full) ? NL'(1 << sel) : '0;
            hd        = (iq.size() > 0) ? iq[0] : 0;
            exp_rv    = (iq.size() > 0) && rv[hd];
            exp_resp  = lane[hd];
            yumi      = exp_rv && ($urandom_range(0, 9) < 7);
            exp_yumi  = yumi ? NL'(1 << hd) : '0;

            mem_cmd        = cmd;
            mem_cmd_v      = cv;
            link_cmd_ready = lrdy;
            link_resp_v    = rv;
            link_resp      = {lane[1], lane[0]};
            mem_resp_yumi  = yumi;
            #1;
            total++; if (mem_cmd_ready !== exp_ready) begin bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, mem_cmd_ready, exp_ready); end
            total++; if (link_cmd_v !== exp_lv) begin bad++; $display("FAIL rand_link_cmd_v c=%0d got=%b want=%b", c, link_cmd_v, exp_lv); end
            total++; if (mem_resp_v !== exp_rv) begin bad++; $display("FAIL rand_resp_v c=%0d got=%b want=%b", c, mem_resp_v, exp_rv); end
            if (exp_rv) begin
                total++; if (mem_resp !== exp_resp) begin bad++; $display("FAIL rand_resp c=%0d got=%h want=%h", c, mem_resp, exp_resp); end
            end
            total++; if (link_resp_yumi !== exp_yumi) begin bad++; $display("FAIL rand_yumi c=%0d got=%b want=%b", c, link_resp_yumi, exp_yumi); end
            total++; if (outstanding !== OW'(iq.size()) || idle !== (iq.size() == 0)) begin
                bad++; $display("FAIL rand_outstanding c=%0d got=%0d/%b want=%0d", c, outstanding, idle, iq.size());
            end
            tick();
            if (yumi) begin
                void'(iq.pop_front());
                void'(lq[hd].pop_front());
            end
            if (cv && exp_ready) begin
                iq.push_back(sel);
                lq[sel].push_back(cmd);
            end
        end
        idle_inputs();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_hold_order();
        test_credit_limit();
        test_order_full();
        test_simultaneous();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
